program_loader: RTL and testbench
=================================

# program_loader

Byte-stream writer for the instruction memory of the MIPS-DLX pipeline: the write-side counterpart to instruction fetch, which only reads that memory. On a start request it accepts bytes over a valid/ready handshake and assembles them big-endian into 32-bit words. It writes each word to consecutive 10-bit instruction addresses, holding the CPU frozen until the program image, terminated by an end marker, is fully loaded.

## Interface

Parameters:
- ADDR_W, 10, instruction memory address width (matches PC width)
- END_WORD, 32'hFFFF_FFFF, end-of-program marker word

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a load session (sampled only in IDLE)
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  write data
- cpu_hold  out  1  freeze pipeline/PC while high
- load_done  out  1  one-cycle pulse at end of session
- word_count  out  ADDR_W+1  words written this session (0..1024)
- overflow_err  out  1  memory filled without end marker; cleared on next start

## Operation

- States: IDLE, LOAD, WRITE, DONE.
- IDLE: rx_ready=0, cpu_hold=0. When start=1: clear word_count, byte counter, address, overflow_err; go to LOAD.
- LOAD: rx_ready=1, cpu_hold=1.
  - A byte is accepted when rx_valid && rx_ready.
  - Byte k (k=0..3) is placed in the word buffer bits [31-8k:24-8k]; the first byte received is the MSB.
  - On the 4th accepted byte go to WRITE.
  - start is ignored.
- WRITE (exactly 1 cycle): rx_ready=0, imem_we=1, imem_wdata=assembled word, imem_addr=current address; word_count increments.
  - If word==END_WORD, go to DONE. The marker is written so the CPU sees it as halt.
  - Else if address==2^ADDR_W-1, set overflow_err and go to DONE.
  - Else increment address, clear byte counter, return to LOAD.
- DONE (1 cycle): load_done=1, cpu_hold=1, rx_ready=0; then IDLE.
- imem_addr, imem_wdata and imem_we are don't-care/0 outside WRITE. imem_we is 0 outside WRITE.
- word_count and overflow_err hold their values in IDLE until the next start.

## Timing

- Reset values: state IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, load_done=0, word_count=0, overflow_err=0.
  - Byte counter and word buffer are also cleared.
- start high at edge N → LOAD at N+1; rx_ready and cpu_hold are high from cycle N+1.
- 4th byte accepted at edge M → imem_we=1 during cycle M+1 → LOAD or DONE at M+2.
- Peak throughput: 4 bytes per 5 cycles.
- rx_valid may drop between bytes at any time; partial words are retained indefinitely.
- End marker written at cycle W → load_done pulse during W+1, cpu_hold=0 from W+2.
- Reset mid-session, including during WRITE:
  - The write is suppressed in the cycle reset is sampled; from the next cycle all outputs return to reset values.
  - The partial word is discarded and no load_done is issued.
- Simultaneous start and reset: reset wins.
- Address wrap: the address never wraps; the word at 1023 is the last one written, then overflow_err=1 and word_count=1024.

## Test plan

- Basic load: start, bytes 20 01 00 05, 00 00 00 00, FF FF FF FF -> writes [0]=0x20010005, [1]=0x00000000, [2]=0xFFFFFFFF; load_done one cycle after the third write; word_count=3; overflow_err=0.
- Gapped stream: same bytes with rx_valid low 0–7 random cycles between bytes -> identical writes and addresses; imem_we pulses exactly 3 times, each 1 cycle.
- Handshake: rx_valid held high continuously -> rx_ready low in every WRITE/DONE cycle; no byte is lost or duplicated; 4 bytes are accepted per 5 cycles.
- Overflow: 1024 non-marker words (data = address) -> last write at addr 1023, overflow_err=1, word_count=1024, load_done pulses, no write to addr 0 afterwards.
- Reset mid-word: after 2 bytes of word 1, assert reset 1 cycle -> all outputs 0, no write; new start with 1 word + marker -> writes at addr 0 and 1 only.
- Ignored start: pulse start during LOAD and at the DONE cycle -> no effect on address/count; a new session begins only from IDLE.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream loader for instruction memory: assembles big-endian words from a valid/ready
// byte stream and writes them to consecutive addresses while holding the CPU frozen.
module program_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          byte_cnt_d = '0;
          addr_d     = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        // rx_ready is high throughout LOAD, so rx_valid alone marks an accepted byte
        if (rx_valid) begin
          case (byte_cnt_q)
            2'd0:    word_d[31:24] = rx_data;
            2'd1:    word_d[23:16] = rx_data;
            2'd2:    word_d[15:8]  = rx_data;
            default: word_d[7:0]   = rx_data;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        count_d = count_q + 1'b1;
        if (word_q == END_WORD) begin
          state_d = StDone;
        end else if (addr_q == LastAddr) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          addr_d     = addr_q + 1'b1;
          byte_cnt_d = '0;
          state_d    = StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rx_ready     = (state_q == StLoad);
    // Gate with reset so a write in flight is dropped in the cycle reset is sampled
    imem_we      = (state_q == StWrite) && !reset;
    imem_addr    = imem_we ? addr_q : '0;
    imem_wdata   = imem_we ? word_q : '0;
    cpu_hold     = (state_q != StIdle);
    load_done    = (state_q == StDone);
    word_count   = count_q;
    overflow_err = ovf_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random byte streams checked against a word-level
// model of the expected memory writes, counts and flags.
module tb_program_loader;

  localparam int unsigned AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          overflow_err;

  program_loader #(.ADDR_W(AW), .END_WORD(32'hFFFF_FFFF)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .word_count  (word_count),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  int          cyc = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc;
  int          done_cnt, done_cyc, acc_cnt, rdy_viol, we_wide;
  logic        we_prev = 1'b0;
  int          start_cyc;

  // Stimulus bytes of the current session
  logic [7:0]  tx[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc = cyc;
      if (we_prev) we_wide++;
    end
    we_prev = imem_we;
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_valid && rx_ready) acc_cnt++;
    if (rx_ready && (imem_we || load_done)) rdy_viol++;
  end

  task automatic clr_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    acc_cnt  = 0;
    rdy_viol = 0;
    we_wide  = 0;
    wr_cyc   = -1;
    done_cyc = -1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic push_word(input logic [31:0] w);
    tx.push_back(w[31:24]);
    tx.push_back(w[23:16]);
    tx.push_back(w[15:8]);
    tx.push_back(w[7:0]);
  endtask

  task automatic start_session();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Present one byte after an optional idle gap; returns once it has been accepted
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rx_ready) ok = 1'b1;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_range(input int from, input int to, input int gapmax);
    bit ok;
    for (int i = from; i < to; i++) begin
      send_byte(tx[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, ok);
      if (!ok) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_byte: byte %0d not accepted, rx_ready=%b required 1", i, rx_ready);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 20 && cpu_hold; i++) begin
      @(posedge clock);
      #1;
    end
    n_tests++;
    if (cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: cpu_hold=%b required 0", name, cpu_hold);
    end
  endtask

  // Word-level model: group bytes into big-endian words written to address 0,1,2,...;
  // stop after the end marker or after the last address is used.
  task automatic check_session(input string name);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] w;
    bit          eov;
    int          bad;
    eov = 1'b0;
    for (int i = 0; i + 3 < tx.size(); i += 4) begin
      w = {tx[i], tx[i+1], tx[i+2], tx[i+3]};
      ea.push_back(ed.size());
      ed.push_back(w);
      if (w == 32'hFFFF_FFFF) break;
      if (ed.size() == (1 << AW)) begin
        eov = 1'b1;
        break;
      end
    end
    n_tests++;
    if (wr_addr.size() != ed.size()) begin
      n_fail++;
      $display("FAIL %s_nwrites: got %0d required %0d", name, wr_addr.size(), ed.size());
    end else begin
      bad = 0;
      for (int i = 0; i < ed.size(); i++) begin
        if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
          if (bad == 0)
            $display("FAIL %s_write[%0d]: got [%0d]=%h required [%0d]=%h", name, i,
                     wr_addr[i], wr_data[i], ea[i], ed[i]);
          bad++;
        end
      end
      if (bad != 0) n_fail++;
    end
    n_tests++;
    if (word_count !== (AW+1)'(ed.size())) begin
      n_fail++;
      $display("FAIL %s_word_count: got %0d required %0d", name, word_count, ed.size());
    end
    n_tests++;
    if (overflow_err !== eov) begin
      n_fail++;
      $display("FAIL %s_overflow: got %b required %b", name, overflow_err, eov);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_load_done: got %0d pulses required 1", name, done_cnt);
    end
    n_tests++;
    if (we_wide != 0) begin
      n_fail++;
      $display("FAIL %s_we_width: got %0d multi-cycle pulses required 0", name, we_wide);
    end
  endtask

  task automatic check_quiet(input string name);
    n_tests++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, word_count,
         overflow_err} !== '0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b we=%b addr=%h data=%h hold=%b done=%b cnt=%0d ovf=%b required 0",
               name, rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done,
               word_count, overflow_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;  // reset must win over start
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset_outputs");
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_quiet("reset_idle");
  endtask

  task automatic test_basic();
    clr_mon();
    tx.delete();
    push_word(32'h2001_0005);
    push_word(32'h0000_0000);
    push_word(32'hFFFF_FFFF);
    start_session();
    send_range(0, tx.size(), 0);
    wait_idle("basic");
    check_session("basic");
    n_tests++;
    if (done_cyc != wr_cyc + 1) begin
      n_fail++;
      $display("FAIL basic_done_timing: load_done at cycle %0d required %0d", done_cyc,
               wr_cyc + 1);
    end
  endtask

  task automatic test_gapped();
    for (int r = 0; r < 3; r++) begin
      clr_mon();
      tx.delete();
      for (int k = 0; k < 2 + r; k++) push_word(rand_word());
      push_word(32'hFFFF_FFFF);
      start_session();
      send_range(0, tx.size(), 7);
      wait_idle("gapped");
      check_session("gapped");
    end
  endtask

  task automatic test_handshake();
    clr_mon();
    tx.delete();
    push_word(rand_word());
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    start_session();
    send_range(0, tx.size(), 0);
    wait_idle("handshake");
    check_session("handshake");
    n_tests++;
    if (acc_cnt != tx.size()) begin
      n_fail++;
      $display("FAIL handshake_accepts: got %0d required %0d", acc_cnt, tx.size());
    end
    n_tests++;
    if (rdy_viol != 0) begin
      n_fail++;
      $display("FAIL handshake_ready_low: got %0d violations required 0", rdy_viol);
    end
    // 3 words at 5 cycles each: load_done in the cycle after edge start+15
    n_tests++;
    if (done_cyc - start_cyc != 15) begin
      n_fail++;
      $display("FAIL handshake_rate: load_done after %0d cycles required 15",
               done_cyc - start_cyc);
    end
  endtask

  task automatic test_ignored_start();
    clr_mon();
    tx.delete();
    push_word(rand_word());
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    start_session();
    send_range(0, 2, 2);
    start = 1'b1;
    send_range(2, 3, 0);
    start = 1'b0;
    send_range(3, tx.size(), 1);
    // now in the marker WRITE cycle; next cycle is DONE
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    n_tests++;
    if (rx_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_idle: rdy=%b hold=%b required 0 0", rx_ready, cpu_hold);
    end
    check_session("ignored_start");
  endtask

  task automatic test_reset_mid();
    clr_mon();
    tx.delete();
    push_word(rand_word());
    push_word(rand_word());
    start_session();
    send_range(0, 6, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_quiet("reset_mid_outputs");
    n_tests++;
    if (wr_addr.size() != 1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_writes: got %0d writes %0d done required 1 0",
               wr_addr.size(), done_cnt);
    end
    // Reset landing in a WRITE cycle must drop that write
    clr_mon();
    start_session();
    send_range(0, 4, 0);
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_write_we: got %b required 0", imem_we);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_quiet("reset_in_write_outputs");
    n_tests++;
    if (wr_addr.size() != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_in_write_writes: got %0d writes %0d done required 0 0",
               wr_addr.size(), done_cnt);
    end
    clr_mon();
    tx.delete();
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    start_session();
    send_range(0, tx.size(), 3);
    wait_idle("reset_resume");
    check_session("reset_resume");
  endtask

  task automatic test_overflow();
    clr_mon();
    tx.delete();
    for (int a = 0; a < (1 << AW); a++) push_word(32'(a));
    start_session();
    send_range(0, tx.size(), 0);
    wait_idle("overflow");
    repeat (5) @(posedge clock);
    #1;
    check_session("overflow");
    n_tests++;
    if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 32'd1023) begin
      n_fail++;
      $display("FAIL overflow_last_addr: got %0d writes, last addr %0d required 1023",
               wr_addr.size(), (wr_addr.size() == 0) ? -1 : int'(wr_addr[wr_addr.size()-1]));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_handshake();
    test_ignored_start();
    test_reset_mid();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
